tlcd_frame_writer: RTL and testbench
====================================

TLCD_FRAME_WRITER -- requirements
Module: tlcd_frame_writer

Interface
REQ-001 Parameter POWERUP_CYC, default 750000, sets the idle wait after reset before the first command (15 ms at 50 MHz).
REQ-002 Parameter E_HIGH_CYC, default 25, sets the number of cycles TLCD_E is held high per byte.
REQ-003 Parameter GAP_CYC, default 2000, sets the wait after TLCD_E falls for every byte except Clear Display.
REQ-004 Parameter CLR_GAP_CYC, default 100000, sets the wait after TLCD_E falls for Clear Display (0x01).
REQ-005 Signal CLK, input, 1 bit: clock.
REQ-006 Signal RST, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Signal UPDATE, input, 1 bit: single-cycle request to write a new frame.
REQ-008 Signal TEXT_UPPER, input, 128 bits: line 1 text, column 0 at [127:120].
REQ-009 Signal TEXT_LOWER, input, 128 bits: line 2 text, column 0 at [127:120].
REQ-010 Signal BUSY, output, 1 bit: high in every state except IDLE.
REQ-011 Signal FRAME_DONE, output, 1 bit: one-cycle pulse when a frame's last byte gap ends.
REQ-012 Signals TLCD_E, TLCD_RS and TLCD_RW, outputs, 1 bit each: HD44780 strobes.
REQ-013 Signal TLCD_DATA, output, 8 bits: HD44780 data bus.

Function
REQ-014 States SHALL be: PWR_WAIT, INIT, IDLE, ADDR_U, DATA_U, ADDR_L, DATA_L, FIN.
REQ-015 Each byte write SHALL follow this sequence:
- 1 setup cycle with RS and DATA valid and E=0;
- E_HIGH_CYC cycles with E=1;
- then GAP_CYC cycles with E=0, or CLR_GAP_CYC cycles for byte 0x01.
REQ-016 RS and DATA SHALL stay stable from the setup cycle through the end of the gap.
REQ-017 TLCD_RW SHALL be 0 at all times.
REQ-018 PWR_WAIT SHALL last POWERUP_CYC cycles and then enter INIT.
REQ-019 INIT SHALL write commands 0x38, 0x0C, 0x06, 0x01 in that order with RS=0, then enter IDLE.
REQ-020 In IDLE with UPDATE=1 or pending=1, the block SHALL:
- copy the frame source into the working line registers;
- clear pending;
- enter ADDR_U.
The frame source is TEXT_UPPER/TEXT_LOWER when UPDATE=1, otherwise the shadow registers.
REQ-021 ADDR_U SHALL write command 0x80 with RS=0.
REQ-022 DATA_U SHALL write 16 bytes with RS=1, working_upper[127:120] first and [7:0] last.
REQ-023 ADDR_L SHALL write 0xC0 with RS=0, and DATA_L SHALL write 16 bytes of working_lower in the same order as DATA_U.
REQ-024 FIN SHALL last 1 cycle, assert FRAME_DONE, and return to IDLE.
REQ-025 A frame SHALL therefore be 34 bytes, lasting 34×(1+E_HIGH_CYC+GAP_CYC)+1 cycles from the IDLE exit to FRAME_DONE.
REQ-026 UPDATE with BUSY=1 (any state, including PWR_WAIT and INIT) SHALL capture both TEXT inputs into the shadow registers and set pending.
REQ-027 Later UPDATEs while busy SHALL overwrite the shadow registers, so only the newest frame is kept.
REQ-028 After FIN, or at the end of INIT, a set pending SHALL start the next frame from the shadow registers on the first IDLE cycle.
REQ-029 An UPDATE arriving in the FIN cycle SHALL be treated as a busy-time request (REQ-026).
REQ-030 TEXT input changes SHALL NOT affect a frame in progress; only the latched working copy is used.
REQ-031 The byte index counter (0..15) SHALL wrap to 0 when leaving DATA_U and DATA_L.
REQ-032 The delay counter SHALL be wide enough for max(POWERUP_CYC, CLR_GAP_CYC) without overflow.

Reset
REQ-033 RST=1 SHALL immediately force the following, at any time, including mid-byte with E=1:
- state to PWR_WAIT;
- TLCD_E, TLCD_RS, TLCD_RW and FRAME_DONE to 0;
- TLCD_DATA to 0x00 and BUSY to 1;
- pending, all counters, and the working and shadow registers to 0.
REQ-034 After RST is released, the full power-up wait and INIT sequence SHALL repeat, and any pre-reset frame SHALL be discarded.

Verification
REQ-035 All scenarios SHALL use POWERUP_CYC=10, E_HIGH_CYC=2, GAP_CYC=4 and CLR_GAP_CYC=8.
REQ-036 The bench SHALL cover these scenarios:
- Reset release, no UPDATE -> E pulses carry 0x38, 0x0C, 0x06, 0x01 with RS=0; the first E rise is 11 cycles after release; the gap after 0x01 is 8 cycles; BUSY falls after the 0x01 gap.
- In IDLE, UPDATE with TEXT_UPPER="PRESS ANY KEY   " and TEXT_LOWER={8'h00,"  TO START GAME"} -> captured bytes are 0x80, 'P'…' ', 0xC0, 0x00, ' ', ' ', 'T'…'E'; FRAME_DONE pulses exactly 239 cycles after the UPDATE cycle.
- TEXT inputs change every cycle during a frame -> the captured bytes equal only the values latched at UPDATE.
- Three UPDATEs mid-frame with texts A, B, C -> the current frame completes, exactly one further frame follows carrying text C, then BUSY=0.
- UPDATE during INIT -> the frame starts on the first IDLE cycle after 0x01 and completes.
- RST asserted while E=1 in DATA_U -> E drops in the same cycle; after release the INIT sequence repeats; no data bytes are sent until the next UPDATE.

Source files
------------

// File: rtl/tlcd_frame_writer.sv
// HD44780 frame writer: runs the power-up wait and the INIT command list, then
// writes a 2x16 text frame per UPDATE, holding back the newest request while busy.
module tlcd_frame_writer #(
    parameter int POWERUP_CYC = 750000,
    parameter int E_HIGH_CYC  = 25,
    parameter int GAP_CYC     = 2000,
    parameter int CLR_GAP_CYC = 100000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         UPDATE,
    input  logic [127:0] TEXT_UPPER,
    input  logic [127:0] TEXT_LOWER,
    output logic         BUSY,
    output logic         FRAME_DONE,
    output logic         TLCD_E,
    output logic         TLCD_RS,
    output logic         TLCD_RW,
    output logic [7:0]   TLCD_DATA
);
    localparam int MAX_PG  = (POWERUP_CYC > CLR_GAP_CYC) ? POWERUP_CYC : CLR_GAP_CYC;
    localparam int MAX_EG  = (E_HIGH_CYC > GAP_CYC) ? E_HIGH_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_PG > MAX_EG) ? MAX_PG : MAX_EG;
    localparam int DW      = $clog2(MAX_CYC + 1);

    localparam logic [DW-1:0] PWR_LAST = DW'(POWERUP_CYC - 1);
    localparam logic [DW-1:0] EH_LAST  = DW'(E_HIGH_CYC - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);
    localparam logic [DW-1:0] CLR_LAST = DW'(CLR_GAP_CYC - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, ADDR_U, DATA_U, ADDR_L, DATA_L, FIN
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_GAP} phase_t;

    // {RS, DATA} of the byte owned by a state; idx 0 selects bits [127:120].
    function automatic logic [8:0] byte_sel(input state_t st, input logic [3:0] idx,
                                            input logic [1:0] ini, input logic [127:0] wu,
                                            input logic [127:0] wl);
        logic [8:0] b;
        case (st)
            INIT: begin
                case (ini)
                    2'd0:    b = 9'h038;
                    2'd1:    b = 9'h00C;
                    2'd2:    b = 9'h006;
                    default: b = 9'h001;
                endcase
            end
            ADDR_U:  b = 9'h080;
            DATA_U:  b = {1'b1, wu[{~idx, 3'b000} +: 8]};
            ADDR_L:  b = 9'h0C0;
            DATA_L:  b = {1'b1, wl[{~idx, 3'b000} +: 8]};
            default: b = 9'h000;
        endcase
        return b;
    endfunction

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [3:0]      idx_q, idx_d;
    logic [1:0]      ini_q, ini_d;
    logic            pend_q, pend_d;
    logic [127:0]    wu_q, wu_d, wl_q, wl_d;
    logic [127:0]    su_q, su_d, sl_q, sl_d;
    logic            e_q, e_d, rs_q, rs_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]      data_q, data_d;
    logic [8:0]      sel_s;
    logic [DW-1:0]   gap_last_s;

    // Clear Display needs the long settle time; every other byte uses the short gap.
    assign gap_last_s = (!rs_q && (data_q == 8'h01)) ? CLR_LAST : GAP_LAST;

    // Next-state, byte sequencing and request capture.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        ini_d   = ini_q;
        pend_d  = pend_q;
        wu_d    = wu_q;
        wl_d    = wl_q;
        su_d    = su_q;
        sl_d    = sl_q;

        case (state_q)
            PWR_WAIT: begin
                if (dly_q == PWR_LAST) begin
                    state_d = INIT;
                    phase_d = PH_SETUP;
                    dly_d   = '0;
                    ini_d   = 2'd0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            IDLE: begin
                if (UPDATE || pend_q) begin
                    wu_d    = UPDATE ? TEXT_UPPER : su_q;
                    wl_d    = UPDATE ? TEXT_LOWER : sl_q;
                    pend_d  = 1'b0;
                    state_d = ADDR_U;
                    phase_d = PH_SETUP;
                    dly_d   = '0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FIN: state_d = IDLE;
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_EHIGH;
                        dly_d   = '0;
                    end
                    PH_EHIGH: begin
                        if (dly_q == EH_LAST) begin
                            phase_d = PH_GAP;
                            dly_d   = '0;
                        end else begin
                            dly_d = dly_q + 1'b1;
                        end
                    end
                    PH_GAP: begin
                        if (dly_q == gap_last_s) begin
                            phase_d = PH_SETUP;
                            dly_d   = '0;
                            case (state_q)
                                INIT: begin
                                    if (ini_q == 2'd3) begin
                                        state_d = IDLE;
                                    end else begin
                                        ini_d = ini_q + 2'd1;
                                    end
                                end
                                ADDR_U: begin
                                    state_d = DATA_U;
                                    idx_d   = 4'd0;
                                end
                                DATA_U: begin
                                    idx_d   = idx_q + 4'd1;
                                    state_d = (idx_q == 4'd15) ? ADDR_L : DATA_U;
                                end
                                ADDR_L: begin
                                    state_d = DATA_L;
                                    idx_d   = 4'd0;
                                end
                                DATA_L: begin
                                    idx_d   = idx_q + 4'd1;
                                    state_d = (idx_q == 4'd15) ? FIN : DATA_L;
                                end
                                default: state_d = PWR_WAIT;
                            endcase
                        end else begin
                            dly_d = dly_q + 1'b1;
                        end
                    end
                    default: begin
                        phase_d = PH_SETUP;
                        dly_d   = '0;
                    end
                endcase
            end
        endcase

        // Requests while busy (FIN included) park in the shadow copy; newest wins.
        if (UPDATE && (state_q != IDLE)) begin
            su_d   = TEXT_UPPER;
            sl_d   = TEXT_LOWER;
            pend_d = 1'b1;
        end else begin
            su_d = su_q;
            sl_d = sl_q;
        end

        sel_s  = byte_sel(state_d, idx_d, ini_d, wu_d, wl_d);
        rs_d   = sel_s[8];
        data_d = sel_s[7:0];
        e_d    = (phase_d == PH_EHIGH) && (state_d != PWR_WAIT) &&
                 (state_d != IDLE) && (state_d != FIN);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State, counters, text copies and registered LCD outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= PWR_WAIT;
            phase_q <= PH_SETUP;
            dly_q   <= '0;
            idx_q   <= 4'd0;
            ini_q   <= 2'd0;
            pend_q  <= 1'b0;
            wu_q    <= 128'd0;
            wl_q    <= 128'd0;
            su_q    <= 128'd0;
            sl_q    <= 128'd0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            ini_q   <= ini_d;
            pend_q  <= pend_d;
            wu_q    <= wu_d;
            wl_q    <= wl_d;
            su_q    <= su_d;
            sl_q    <= sl_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign TLCD_E     = e_q;
    assign TLCD_RS    = rs_q;
    assign TLCD_RW    = 1'b0;
    assign TLCD_DATA  = data_q;
endmodule

// File: tb/tb_tlcd_frame_writer.sv
// Bench for tlcd_frame_writer: a byte-queue model of the LCD traffic is compared
// with the DUT every cycle, plus literal checks on the INIT list, timing and frames.
module tb_tlcd_frame_writer;
    localparam int P_PWR = 10;
    localparam int P_EH  = 2;
    localparam int P_GAP = 4;
    localparam int P_CLR = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         UPDATE = 1'b0;
    logic [127:0] TEXT_UPPER = '0;
    logic [127:0] TEXT_LOWER = '0;
    logic         BUSY, FRAME_DONE, TLCD_E, TLCD_RS, TLCD_RW;
    logic [7:0]   TLCD_DATA;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    tlcd_frame_writer #(
        .POWERUP_CYC(P_PWR), .E_HIGH_CYC(P_EH), .GAP_CYC(P_GAP), .CLR_GAP_CYC(P_CLR)
    ) dut (
        .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .TEXT_UPPER(TEXT_UPPER),
        .TEXT_LOWER(TEXT_LOWER), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
        .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: queue of bytes still to be written --------
    typedef enum int {M_PW, M_BYTES, M_FIN, M_IDLE} mmode_t;
    typedef struct {
        bit       rs;
        bit [7:0] d;
        int       gap;
        bit       frm;
    } item_t;

    mmode_t       m_mode = M_PW;
    int           m_pw = 0;
    int           m_pos = 0;
    item_t        mq[$];
    bit           m_pend = 1'b0;
    bit           m_frm = 1'b0;
    logic [127:0] m_su = '0;
    logic [127:0] m_sl = '0;

    task automatic push_init();
        mq.push_back('{1'b0, 8'h38, P_GAP, 1'b0});
        mq.push_back('{1'b0, 8'h0C, P_GAP, 1'b0});
        mq.push_back('{1'b0, 8'h06, P_GAP, 1'b0});
        mq.push_back('{1'b0, 8'h01, P_CLR, 1'b0});
    endtask

    task automatic push_frame(input logic [127:0] u, input logic [127:0] l);
        mq.push_back('{1'b0, 8'h80, P_GAP, 1'b1});
        for (int i = 0; i < 16; i++) mq.push_back('{1'b1, u[127-8*i -: 8], P_GAP, 1'b1});
        mq.push_back('{1'b0, 8'hC0, P_GAP, 1'b1});
        for (int i = 0; i < 16; i++) mq.push_back('{1'b1, l[127-8*i -: 8], P_GAP, 1'b1});
    endtask

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_mode = M_PW; m_pw = 0; m_pos = 0; mq.delete();
            m_pend = 1'b0; m_su = '0; m_sl = '0;
        end else begin
            if (UPDATE && (m_mode != M_IDLE)) begin
                m_su = TEXT_UPPER; m_sl = TEXT_LOWER; m_pend = 1'b1;
            end
            case (m_mode)
                M_PW: begin
                    if (m_pw == P_PWR - 1) begin push_init(); m_mode = M_BYTES; m_pos = 0; end
                    else m_pw++;
                end
                M_BYTES: begin
                    m_pos++;
                    if (m_pos == 1 + P_EH + mq[0].gap) begin
                        m_frm = mq[0].frm;
                        void'(mq.pop_front());
                        m_pos = 0;
                        if (mq.size() == 0) m_mode = m_frm ? M_FIN : M_IDLE;
                    end
                end
                M_FIN: m_mode = M_IDLE;
                default: begin
                    if (UPDATE || m_pend) begin
                        if (UPDATE) push_frame(TEXT_UPPER, TEXT_LOWER);
                        else push_frame(m_su, m_sl);
                        m_pend = 1'b0; m_mode = M_BYTES; m_pos = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of all outputs; RS/DATA only matter while a byte is on the bus.
    logic [12:0] exp_v, act_v, mask_v;
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            exp_v = 13'h1000; mask_v = 13'h1FFF;
        end else begin
            exp_v  = {m_mode != M_IDLE, m_mode == M_FIN,
                      (m_mode == M_BYTES) && (m_pos >= 1) && (m_pos <= P_EH), 1'b0, 9'h000};
            mask_v = 13'h1E00;
            if (m_mode == M_BYTES) begin
                exp_v[8:0] = {mq[0].rs, mq[0].d};
                mask_v     = 13'h1FFF;
            end
        end
        act_v = {BUSY, FRAME_DONE, TLCD_E, TLCD_RW, TLCD_RS, TLCD_DATA};
        n_checks++;
        if ((act_v & mask_v) !== (exp_v & mask_v)) begin
            n_fail++;
            $display("FAIL cycle_compare cyc=%0d {busy,done,e,rw,rs,data} got %04h expected %04h mask %04h",
                     cyc, act_v, exp_v, mask_v);
        end
    end

    // ---------------- bus monitor ----------------
    logic [8:0] cap[$];
    int   first_rise = -1, last_fall = 0, busy_fall = 0, done_cnt = 0, done_cyc = 0;
    logic prev_e = 1'b0, prev_busy = 1'b1;
    initial forever begin
        @(negedge CLK);
        if (TLCD_E && !prev_e) begin
            cap.push_back({TLCD_RS, TLCD_DATA});
            if (first_rise < 0) first_rise = cyc;
        end
        if (!TLCD_E && prev_e) last_fall = cyc;
        if (!BUSY && prev_busy) busy_fall = cyc;
        if (FRAME_DONE) begin done_cnt++; done_cyc = cyc; end
        prev_e = TLCD_E; prev_busy = BUSY;
    end

    // ---------------- stimulus helpers ----------------
    int upd_cyc = 0;

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rand_text();
        logic [127:0] t;
        for (int i = 0; i < 16; i++) t[8*i +: 8] = 8'($urandom_range(32, 126));
        return t;
    endfunction

    task automatic pulse_update(input logic [127:0] u, input logic [127:0] l);
        TEXT_UPPER = u; TEXT_LOWER = l; UPDATE = 1'b1; upd_cyc = cyc;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int run = 0;
        int n = 0;
        while (run < 3 && n < max) begin
            tick(); n++;
            if (!BUSY) run++; else run = 0;
        end
        n_checks++;
        if (run < 3) begin
            n_fail++;
            $display("FAIL %s: no idle within %0d cycles", name, max);
        end
    endtask

    task automatic wait_cap(input string name, input int target, input int max);
        int n = 0;
        while (cap.size() < target && n < max) begin tick(); n++; end
        check(name, cap.size() >= target, 1);
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < max) begin tick(); n++; end
        check(name, done_cnt != d0, 1);
    endtask

    task automatic check_init(input string name, input int start);
        logic [8:0] lst [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
        for (int i = 0; i < 4; i++) check(name, cap[start+i], lst[i]);
    endtask

    task automatic check_frame(input string name, input int start,
                               input logic [127:0] u, input logic [127:0] l);
        logic [8:0] e;
        for (int i = 0; i < 34; i++) begin
            if (i == 0)       e = 9'h080;
            else if (i < 17)  e = {1'b1, u[127-8*(i-1) -: 8]};
            else if (i == 17) e = 9'h0C0;
            else              e = {1'b1, l[127-8*(i-18) -: 8]};
            check(name, (start + i < cap.size()) ? longint'(cap[start+i]) : -1, e);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [127:0] u, l, a, b, c, x;
        int base, base2, rel, d0;

        // Reset release with no UPDATE: INIT list, first E timing, clear gap.
        repeat (3) tick();
        check("reset_busy", BUSY, 1);
        check("reset_e", TLCD_E, 0);
        first_rise = -1; base = cap.size();
        RST = 1'b0; rel = cyc;
        wait_idle("init_idle", 200);
        check("init_first_rise", first_rise - rel, 11);
        check("init_count", cap.size() - base, 4);
        check_init("init_bytes", base);
        check("clear_gap", busy_fall - last_fall, P_CLR);

        // Fixed text frame: byte list and latency from UPDATE to FRAME_DONE.
        u = "PRESS ANY KEY   ";
        l = {8'h00, "  TO START GAME"};
        base = cap.size();
        pulse_update(u, l);
        wait_done("frame_done_seen", 400);
        check("frame_latency", done_cyc - upd_cyc, 239);
        wait_idle("press_idle", 100);
        check_frame("press_frame", base, u, l);
        check("pin_P", cap[base+1], 9'h150);
        check("pin_C0", cap[base+17], 9'h0C0);
        check("pin_nul", cap[base+18], 9'h100);
        check("pin_T", cap[base+21], 9'h154);

        // TEXT inputs churn during a frame; only the latched copy may appear.
        a = rand_text(); b = rand_text(); base = cap.size();
        pulse_update(a, b);
        for (int k = 0; k < 260; k++) begin
            TEXT_UPPER = rand_text(); TEXT_LOWER = rand_text();
            tick();
        end
        wait_idle("churn_idle", 200);
        check_frame("churn_frame", base, a, b);

        // Three UPDATEs mid-frame: exactly one follow-up frame carrying the newest text.
        x = rand_text(); a = rand_text(); b = rand_text(); c = rand_text();
        base = cap.size(); d0 = done_cnt;
        pulse_update(x, ~x);
        repeat (30) tick();
        pulse_update(a, ~a);
        repeat (40) tick();
        pulse_update(b, ~b);
        repeat (40) tick();
        pulse_update(c, ~c);
        wait_idle("multi_idle", 1000);
        check("multi_done_count", done_cnt - d0, 2);
        check("multi_byte_count", cap.size() - base, 68);
        check_frame("multi_first", base, x, ~x);
        check_frame("multi_newest", base + 34, c, ~c);

        // UPDATE during INIT: frame follows the INIT list.
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        base = cap.size(); d0 = done_cnt;
        wait_cap("init_started", base + 1, 100);
        x = rand_text();
        pulse_update(x, ~x);
        wait_idle("init_upd_idle", 800);
        check("init_upd_count", cap.size() - base, 38);
        check_init("init_upd_init", base);
        check_frame("init_upd_frame", base + 4, x, ~x);
        check("init_upd_done", done_cnt - d0, 1);

        // Reset while E is high in DATA_U.
        x = rand_text(); base = cap.size();
        pulse_update(x, x);
        wait_cap("data_u_reached", base + 3, 100);
        check("e_high_pre_rst", TLCD_E, 1);
        RST = 1'b1;
        #1;
        check("e_drop_async", TLCD_E, 0);
        check("busy_in_rst", BUSY, 1);
        repeat (3) tick();
        RST = 1'b0;
        base2 = cap.size();
        wait_idle("post_rst_idle", 200);
        repeat (100) tick();
        check("post_rst_count", cap.size() - base2, 4);
        check_init("post_rst_init", base2);

        // Random UPDATE timing against the model.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 300)) tick();
            pulse_update(rand_text(), rand_text());
        end
        wait_idle("random_idle", 1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
